// File: rtl/button_stepper_pkg.sv
// Shared types and default timing for the front-panel button stepper.
// Defaults assume a 100 MHz sysclk.
package button_stepper_pkg;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StFirst  = 3'd1,
      StDelay  = 3'd2,
      StRepeat = 3'd3,
      StLock   = 3'd4
   } chan_state_t;

   localparam int unsigned DefDebounceCycles = 1000000;
   localparam int unsigned DefRepeatDelay    = 50000000;
   localparam int unsigned DefRepeatPeriod   = 10000000;
   localparam int unsigned DefCntW           = 26;

endpackage

// File: rtl/button_channel.sv
// One button: two-flop synchroniser, debounce, and a step FSM with hold-to-repeat.
// The lock input forces the FSM out of stepping until lock is released.
module button_channel
   import button_stepper_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
   parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
   parameter int unsigned REPEAT_PERIOD   = DefRepeatPeriod,
   parameter int unsigned CNT_W           = DefCntW
) (
   input  logic sysclk,
   input  logic reset,
   input  logic raw,
   input  logic lock,
   output logic held,
   output logic step
);

   localparam logic [CNT_W-1:0] DebLast    = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DelayLast  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PeriodLast = CNT_W'(REPEAT_PERIOD - 1);

   logic [1:0]       sync_q;
   logic             level_q, level_d;
   logic             level_prev_q;
   logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
   logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
   chan_state_t      state_q, state_d;
   logic             rise;
   logic             active;

   // Debounce: a level change is accepted only after DEBOUNCE_CYCLES differing samples in a row.
   always_comb begin
      deb_cnt_d = '0;
      level_d   = level_q;
      if (sync_q[1] != level_q) begin
         if (deb_cnt_q == DebLast) begin
            level_d = ~level_q;
         end else begin
            deb_cnt_d = deb_cnt_q + CNT_W'(1);
         end
      end
   end

   assign rise   = level_q & ~level_prev_q;
   assign active = (state_q == StFirst) || (state_q == StDelay) || (state_q == StRepeat);

   always_comb begin
      state_d   = state_q;
      rep_cnt_d = rep_cnt_q + CNT_W'(1);
      step      = 1'b0;
      unique case (state_q)
         StIdle: begin
            rep_cnt_d = '0;
            if (rise) begin
               state_d = StFirst;
            end
         end
         StFirst: begin
            step      = 1'b1;
            rep_cnt_d = '0;
            state_d   = StDelay;
         end
         StDelay: begin
            if (rep_cnt_q == DelayLast) begin
               step      = 1'b1;
               rep_cnt_d = '0;
               state_d   = StRepeat;
            end
         end
         StRepeat: begin
            if (rep_cnt_q == PeriodLast) begin
               step      = 1'b1;
               rep_cnt_d = '0;
            end
         end
         StLock: begin
            rep_cnt_d = '0;
            if (!lock) begin
               state_d = rise ? StFirst : StIdle;
            end
         end
         default: begin
            rep_cnt_d = '0;
            state_d   = StIdle;
         end
      endcase

      // Release wins over a step falling due in the same cycle.
      if (active && !level_q) begin
         step      = 1'b0;
         rep_cnt_d = '0;
         state_d   = StIdle;
      end

      if (lock) begin
         step      = 1'b0;
         rep_cnt_d = '0;
         state_d   = StLock;
      end
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         sync_q       <= '0;
         level_q      <= 1'b0;
         level_prev_q <= 1'b0;
         deb_cnt_q    <= '0;
         rep_cnt_q    <= '0;
         state_q      <= StIdle;
      end else begin
         sync_q       <= {sync_q[0], raw};
         level_q      <= level_d;
         level_prev_q <= level_q;
         deb_cnt_q    <= deb_cnt_d;
         rep_cnt_q    <= rep_cnt_d;
         state_q      <= state_d;
      end
   end

   assign held = level_q;

endmodule

// File: rtl/button_stepper.sv
// Plus/Minus front-panel buttons to one-cycle Scale step pulses.
// Pressing both buttons locks out all steps until both are released.
module button_stepper
   import button_stepper_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
   parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
   parameter int unsigned REPEAT_PERIOD   = DefRepeatPeriod,
   parameter int unsigned CNT_W           = DefCntW
) (
   input  logic sysclk,
   input  logic reset,
   input  logic Bt_Plus_raw,
   input  logic Bt_Minus_raw,
   output logic Plus_step,
   output logic Minus_step,
   output logic Plus_held,
   output logic Minus_held
);

   logic lock_q, lock_d;
   logic lock_active;
   logic plus_lvl, minus_lvl;
   logic plus_pulse, minus_pulse;

   button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .CNT_W          (CNT_W)
   ) u_plus (
      .sysclk(sysclk),
      .reset (reset),
      .raw   (Bt_Plus_raw),
      .lock  (lock_active),
      .held  (plus_lvl),
      .step  (plus_pulse)
   );

   button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .CNT_W          (CNT_W)
   ) u_minus (
      .sysclk(sysclk),
      .reset (reset),
      .raw   (Bt_Minus_raw),
      .lock  (lock_active),
      .held  (minus_lvl),
      .step  (minus_pulse)
   );

   // Lock takes effect in the very cycle both levels are high, not a cycle later.
   always_comb begin
      lock_active = lock_q | (plus_lvl & minus_lvl);
      lock_d      = lock_q ? (plus_lvl | minus_lvl) : (plus_lvl & minus_lvl);
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         lock_q <= 1'b0;
      end else begin
         lock_q <= lock_d;
      end
   end

   assign Plus_step  = plus_pulse & ~lock_active;
   assign Minus_step = minus_pulse & ~lock_active;
   assign Plus_held  = plus_lvl;
   assign Minus_held = minus_lvl;

endmodule
